alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU of the execute stage.
- Adds a valid/ready handshake on both the input and output sides.
- Extends the op set with XOR, SLTU and shifts, plus an iterative multiplier and an optional iterative unsigned divider.
- Sits between the decode/issue logic and the writeback mux; it stalls issue while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two.
- CW, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock; all logic rising-edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept an op this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUControl  input  4  opcode (see Behaviour)
- out_valid  output  1  Result and flags valid
- out_ready  input  1  consumer accepts the result
- Result  output  WIDTH  registered result
- Carry  output  1  carry-out, ADD/SUB only
- OverFlow  output  1  signed overflow, ADD/SUB only
- Zero  output  1  Result == 0
- Negative  output  1  Result[WIDTH-1]

Behaviour:
- Reset: clk and rst are one clock; rst is synchronous and active-low. While rst=0 at a clk edge, the block enters IDLE and clears out_valid, Result, Carry, OverFlow, Zero, Negative and the counter to 0. in_ready=0 while rst=0.
- Reset mid-operation aborts the op; no result is produced.
- Opcodes:
  - 0000 ADD, 0001 SUB (A + ~B + 1)
  - 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed), 0110 SLTU
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount = B[$clog2(WIDTH)-1:0], upper bits of B ignored
  - 1010 MUL (low WIDTH bits of A*B), 1011 MULHU (high WIDTH bits of unsigned A*B)
  - 1100 DIVU, 1101 REMU (only with the optional feature)
  - 1110, 1111: Result=0
- Flags:
  - Carry = carry-out of the WIDTH-bit add/subtract, ADD/SUB only; 0 otherwise.
  - OverFlow = (Sum MSB ≠ A MSB) & ~(op[0] ^ A MSB ^ B MSB), ADD/SUB only; 0 otherwise.
  - Zero and Negative are computed from the final Result for every op.
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- IDLE or DONE, on accept:
  - Single-cycle op: register Result and flags, go to DONE. out_valid=1 the next cycle (latency 1).
  - MUL/MULHU: latch operands, clear the WIDTH*2 accumulator, cnt=0, go to MUL.
  - DIVU/REMU: latch operands, clear the remainder, cnt=0, go to DIV.
- MUL: one shift-add step per cycle (radix-2, LSB first). After WIDTH steps (cnt==WIDTH-1), write the selected half to Result, go to DONE. out_valid rises WIDTH+1 cycles after accept.
- DIV: one restoring step per cycle, MSB first. After WIDTH steps, write the quotient (DIVU) or remainder (REMU), go to DONE. Same latency, WIDTH+1.
- Divide by zero: runs the full WIDTH cycles, then quotient = all ones and remainder = A.
- DONE: hold Result, flags and out_valid=1 stable until out_ready=1.
  - out_ready=1 without a new accept: out_valid→0, go to IDLE.
  - out_ready=1 with a same-cycle accept: back-to-back issue. The new op proceeds as from IDLE; for a single-cycle op, out_valid stays 1 with the new result.
- In MUL/DIV: in_ready=0 and out_valid=0. in_valid and operand changes are ignored (operands were latched at accept).
- Result and flags change only at DONE entry or reset.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: DIV state, restoring divider and opcodes 1100/1101 are present as above.
- Undefined: DIV state and divider logic are absent. 1100/1101 behave like 1110 (single-cycle, Result=0, Zero=1, Carry=OverFlow=Negative=0).

Test Plan:
- WIDTH=32; ADD A=0x7FFFFFFF, B=1 → next cycle out_valid=1, Result=0x80000000, OverFlow=1, Carry=0, Negative=1, Zero=0.
- SUB A=5, B=5 → Result=0, Zero=1, Carry=1, OverFlow=0. SLTU A=1, B=0xFFFFFFFF → Result=1. SLT with the same operands → Result=0.
- SRA A=0x80000000, B=0x24 (shamt 4) → Result=0xF8000000. SLL A=1, B=31 → Result=0x80000000.
- MULHU A=B=0xFFFFFFFF → out_valid exactly 33 cycles after accept, Result=0xFFFFFFFE; MUL with the same operands → Result=1. in_ready=0 throughout.
- With ALU_MC_DIV_EN: DIVU 100/7 → Result=14; REMU → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9. Without the macro: DIVU 100/7 → Result=0 after 1 cycle.
- Hold out_ready=0 for 5 cycles after ADD → Result stable, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xF0/0xFF) → next cycle Result=0x0F, out_valid stays 1. Pull rst low during MUL → next cycle IDLE with all outputs 0, and no stale result appears afterwards.

Source files
------------

// File: rtl/alu_mc_if.sv
// Issue/writeback handshake bundle for alu_mc: operands and opcode in, result and flags out.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             OverFlow;
  logic             Zero;
  logic             Negative;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU with radix-2 multiplier and optional restoring divider (ALU_MC_DIV_EN).
// Latency: 1 cycle for logic/add/shift ops, WIDTH+1 cycles for MUL/MULHU/DIVU/REMU.
// Backpressure: result held in DONE until out_ready; in_ready low while a multi-cycle op runs.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic   clk,
  input  logic   rst,
  alu_mc_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               ovf_q;
  logic               zero_q;
  logic               neg_q;
  logic [CW-1:0]      cnt;
  logic               sel_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   rem;
`endif

  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               is_addsub;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               sc_carry;
  logic               sc_ovf;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mul_res;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [WIDTH-1:0]   div_res;
`endif

  assign in_ready = rst & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Carry     = carry_q;
  assign bus.OverFlow  = ovf_q;
  assign bus.Zero      = zero_q;
  assign bus.Negative  = neg_q;

  always_comb begin
    is_mul    = (bus.ALUControl == OP_MUL) | (bus.ALUControl == OP_MULHU);
`ifdef ALU_MC_DIV_EN
    is_div    = (bus.ALUControl == OP_DIVU) | (bus.ALUControl == OP_REMU);
`else
    is_div    = 1'b0;
`endif
    is_addsub = (bus.ALUControl[3:1] == 3'b000);
    shamt     = bus.B[SW-1:0];
    // SUB reuses the adder as A + ~B + 1; bit 0 of the opcode selects it.
    b_eff     = bus.ALUControl[0] ? ~bus.B : bus.B;
    sum       = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.ALUControl[0]};

    alu_res = '0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
      OP_AND:         alu_res = bus.A & bus.B;
      OP_OR:          alu_res = bus.A | bus.B;
      OP_XOR:         alu_res = bus.A ^ bus.B;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      OP_SLL:         alu_res = bus.A << shamt;
      OP_SRL:         alu_res = bus.A >> shamt;
      OP_SRA:         alu_res = $unsigned($signed(bus.A) >>> shamt);
      default:        alu_res = '0;
    endcase

    sc_carry = is_addsub & sum[WIDTH];
    sc_ovf   = is_addsub & (sum[WIDTH-1] ^ bus.A[WIDTH-1])
             & ~(bus.ALUControl[0] ^ bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
  end

  // Multiplier: b_q shifts right, mcand shifts left, one partial product per cycle.
  always_comb begin
    acc_nxt = acc + (b_q[0] ? mcand : '0);
    mul_res = sel_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
  end

`ifdef ALU_MC_DIV_EN
  // Restoring divider: a_q shifts out dividend bits MSB first and collects quotient bits.
  // A zero divisor always compares as ge, giving all-ones quotient and remainder = A.
  always_comb begin
    trial   = {rem, a_q[WIDTH-1]};
    ge      = trial >= {1'b0, b_q};
    rem_nxt = ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];
    q_nxt   = {a_q[WIDTH-2:0], ge};
    div_res = sel_q ? rem_nxt : q_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
              state       <= MUL;
              out_valid_q <= 1'b0;
              acc         <= '0;
              mcand       <= {{WIDTH{1'b0}}, bus.A};
              b_q         <= bus.B;
              sel_q       <= bus.ALUControl[0];
              cnt         <= '0;
`ifdef ALU_MC_DIV_EN
            end else if (is_div) begin
              state       <= DIV;
              out_valid_q <= 1'b0;
              a_q         <= bus.A;
              b_q         <= bus.B;
              rem         <= '0;
              sel_q       <= bus.ALUControl[0];
              cnt         <= '0;
`endif
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              carry_q     <= sc_carry;
              ovf_q       <= sc_ovf;
              zero_q      <= (alu_res == '0);
              neg_q       <= alu_res[WIDTH-1];
            end
          end else if (state == DONE && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          b_q   <= b_q >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_res;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= (mul_res == '0);
            neg_q       <= mul_res[WIDTH-1];
          end
        end
`ifdef ALU_MC_DIV_EN
        DIV: begin
          rem <= rem_nxt;
          a_q <= q_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= div_res;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= (div_res == '0);
            neg_q       <= div_res[WIDTH-1];
          end
        end
`endif
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Unused in the no-divider build.
  logic unused_div;
  assign unused_div = is_div;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32 with hand-computed expectations.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Issue one op from IDLE and wait (bounded) for out_valid; operands are scrambled after accept.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output bit rdy_seen);
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    lat          = 1;
    rdy_seen     = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic c,
                            input logic o, input logic z, input logic n);
    check({tag, "_result"}, bus.Result, res);
    check({tag, "_flags"}, {28'd0, bus.Carry, bus.OverFlow, bus.Zero, bus.Negative},
          {28'd0, c, o, z, n});
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit rdy;
    bit stale;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.ALUControl = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    expect_out("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // ADD overflow into sign bit
    run(4'b0000, 32'h7FFF_FFFF, 32'h1, lat, rdy);
    check("add_lat", lat, 1);
    expect_out("add", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    drain("add");

    // SUB equal operands
    run(4'b0001, 32'd5, 32'd5, lat, rdy);
    expect_out("sub", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    drain("sub");

    run(4'b0110, 32'd1, 32'hFFFF_FFFF, lat, rdy);
    expect_out("sltu", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("sltu");

    run(4'b0101, 32'd1, 32'hFFFF_FFFF, lat, rdy);
    expect_out("slt", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("slt");

    // Shift amount uses only B[4:0]
    run(4'b1001, 32'h8000_0000, 32'h24, lat, rdy);
    expect_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("sra");

    run(4'b0111, 32'd1, 32'd31, lat, rdy);
    expect_out("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("sll");

    run(4'b1000, 32'h8000_0000, 32'd31, lat, rdy);
    expect_out("srl", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("srl");

    run(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, lat, rdy);
    expect_out("and", 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("and");

    run(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, lat, rdy);
    expect_out("or", 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("or");

    run(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, lat, rdy);
    expect_out("op_f", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("op_f");

    // Multiplier
    run(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rdy);
    check("mulhu_lat", lat, 33);
    check("mulhu_in_ready_low", {31'd0, rdy}, 32'd0);
    expect_out("mulhu", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("mulhu");

    run(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rdy);
    check("mul_lat", lat, 33);
    expect_out("mul", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("mul");

    run(4'b1010, 32'h0000_3039, 32'd100, lat, rdy);
    expect_out("mul2", 32'h0012_D644, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("mul2");

    // Divider
`ifdef ALU_MC_DIV_EN
    run(4'b1100, 32'd100, 32'd7, lat, rdy);
    check("divu_lat", lat, 33);
    expect_out("divu", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("divu");
    run(4'b1101, 32'd100, 32'd7, lat, rdy);
    expect_out("remu", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("remu");
    run(4'b1100, 32'd12345, 32'd0, lat, rdy);
    expect_out("divu_by0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("divu_by0");
    run(4'b1101, 32'd9, 32'd0, lat, rdy);
    expect_out("remu_by0", 32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("remu_by0");
`else
    run(4'b1100, 32'd100, 32'd7, lat, rdy);
    check("divu_off_lat", lat, 1);
    expect_out("divu_off", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("divu_off");
`endif

    // Backpressure hold, then back-to-back issue
    run(4'b0000, 32'd3, 32'd4, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_result", bus.Result, 32'd7);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.ALUControl = 4'b0100;
    bus.A          = 32'hF0;
    bus.B          = 32'hFF;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
    expect_out("b2b_xor", 32'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("b2b");

    // Reset in the middle of a multiply
    bus.ALUControl = 4'b1010;
    bus.A          = 32'd6;
    bus.B          = 32'd7;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    expect_out("midrst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale = 1'b1;
    end
    check("midrst_no_stale", {31'd0, stale}, 32'd0);
    check("midrst_idle", {31'd0, bus.in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
